ram_port_ctrl: RTL
==================

Name: ram_port_ctrl

Overview:
- Single-outstanding load/store controller between the CPU memory stage and the word-addressed `ram` block.
- Accepts byte-addressed requests over a valid/ready handshake and checks alignment.
- Drives the ram read/write strobes and holds them until `rrdy`/`wrdy`/`exc` comes back.
- Returns one response pulse per request, carrying read data and an error code.

Parameters:
- ADDR_SHIFT, 2, byte-to-word shift; word index = req_addr >> ADDR_SHIFT; alignment check uses req_addr[ADDR_SHIFT-1:0].
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept; equals (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  2  0 = ok, 1 = misaligned, 2 = ram exception, 3 = timeout.
- ram_r_addr  out  32  word index to ram.
- ram_w_addr  out  32  word index to ram; same value as ram_r_addr.
- ram_w_line  out  32  store data to ram.
- ram_read  out  1  ram read strobe.
- ram_write  out  1  ram write strobe.
- ram_r_line  in  32  ram read data.
- ram_rrdy  in  1  ram read-done pulse.
- ram_wrdy  in  1  ram write-done pulse.
- ram_exc  in  1  ram exception; sticky until the next successful ram access.

Behaviour:
- Reset: state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; ram_read=0, ram_write=0; addresses and ram_w_line=0; timeout counter=0.
- req_ready is 0 while rst is high.
- Reset mid-operation: strobes drop at that edge and no rsp_valid is produced. A ram write already sampled by ram may still land.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, on req_valid with req_ready (acceptance edge E0):
  - Latch word index, req_we and req_wdata.
  - If the alignment bits are nonzero: go to RESP with err=1; no ram strobe is ever raised.
  - Otherwise: go to REQ; ram_read = !req_we, ram_write = req_we.
- REQ lasts exactly one cycle with the strobe high, then goes to WAIT.
  - ram_rrdy, ram_wrdy and ram_exc are ignored in REQ, because ram_exc may still hold a stale value from a prior fault.
- WAIT holds the strobe high and samples the ram each cycle:
  - Load and ram_rrdy: capture ram_r_line into rsp_rdata, err=0.
  - Store and ram_wrdy: err=0, rsp_rdata=0.
  - Else ram_exc: err=2, rsp_rdata=0.
  - On any of these, go to RESP and drop the strobe at that same edge.
  - Done takes priority over exc when both are high.
  - The ram sees the strobe together with its own ready flag at that edge, so no second access occurs.
- RESP: rsp_valid=1 for exactly one cycle; next edge clears rsp_valid and returns to IDLE.
  - rsp_rdata and rsp_err hold until the next response.
- Latency with a zero-wait ram: acceptance at E0, ram acts at E1, capture at E2, rsp_valid high during cycle E2–E3, req_ready high again after E3.
  - Throughput is 1 request per 4 cycles.
  - A misaligned request gives rsp_valid in the cycle after E0.
- Addresses and ram_w_line are stable from REQ through WAIT. Out-of-range word indexes are passed through unchanged; the ram reports them via exc.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle with no done/exc.
  - When it reaches TIMEOUT_CYCLES: drop the strobe, go to RESP with err=3, rsp_rdata=0.
- Undefined: no counter; WAIT persists until done or exc, and err=3 never occurs.

Test Plan:
- Store 0xDEADBEEF at addr 0x10, then load 0x10 → store response err=0; load response rsp_rdata=0xDEADBEEF, err=0; ram_w_addr=4 during the store; ram_write high exactly 2 cycles.
- Load addr 0x13 → rsp_valid in the cycle after acceptance, err=1; ram_read/ram_write never high.
- Load addr 0x1000 (word 1024) against a 1024-word ram → err=2, rsp_rdata=0. An immediate load of 0x10 then returns err=0 with correct data, proving the stale exc is ignored in REQ.
- Back-to-back req_valid held high for 3 loads → exactly 3 rsp_valid pulses, 4 cycles apart; req_ready low except in IDLE.
- Assert rst during WAIT of a load → no rsp_valid; strobes 0 after the edge; req_ready=1 on the first cycle after rst falls.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, ram_rrdy/ram_exc tied 0 → err=3 response after 16 WAIT cycles. Without the macro: no response after 100 cycles.

Source files
------------

// File: rtl/ram_port_ctrl.sv
// Single-outstanding load/store controller between the CPU memory stage and a word-addressed ram.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state watchdog that aborts with err=3.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// REQ   | strobe raised for its first cycle; ram status ignored (exc may be stale)
// WAIT  | strobe held; ram done/exc sampled each cycle
// RESP  | one-cycle response pulse, then back to IDLE
module ram_port_ctrl #(
    parameter int ADDR_SHIFT     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] ram_r_addr,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_w_line,
    output logic        ram_read,
    output logic        ram_write,
    input  logic [31:0] ram_r_line,
    input  logic        ram_rrdy,
    input  logic        ram_wrdy,
    input  logic        ram_exc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_EXC     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        misaligned;
    logic        ram_done;
    logic        timeout;

    assign misaligned = |req_addr[ADDR_SHIFT-1:0];
    // The strobe itself records whether the access is a load or a store.
    assign ram_done   = (read_q & ram_rrdy) | (write_q & ram_wrdy);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Terminal compare at TIMEOUT_CYCLES-1 so exactly TIMEOUT_CYCLES WAIT cycles elapse.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == REQ) begin
            cnt_d = '0;
        end else if (state_q == WAIT && !ram_done && !ram_exc && !timeout) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        read_d  = read_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr >> ADDR_SHIFT;
                    wdata_d = req_wdata;
                    if (misaligned) begin
                        state_d = RESP;
                        err_d   = ERR_ALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        read_d  = !req_we;
                        write_d = req_we;
                    end
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ram_done) begin
                    state_d = RESP;
                    err_d   = ERR_OK;
                    rdata_d = read_q ? ram_r_line : '0;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else if (ram_exc) begin
                    state_d = RESP;
                    err_d   = ERR_EXC;
                    rdata_d = '0;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign ram_r_addr = addr_q;
    assign ram_w_addr = addr_q;
    assign ram_w_line = wdata_q;
    assign ram_read   = read_q;
    assign ram_write  = write_q;

endmodule
